// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : imem_loader_pkg                                                |
// | Purpose : Shared constants and state encoding for the IMEM boot loader.  |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 64;  // words in the instruction memory
  localparam int IMEM_ADDR_W = 6;   // log2(IMEM_DEPTH)
  localparam int WCNT_W      = 7;   // wide enough to hold IMEM_DEPTH itself

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : imem_loader_if                                                 |
// | Purpose : Bundles the loader's byte-stream input, IMEM write port and    |
// |           boot status signals.                                           |
// | Ports   : slave  = loader side (consumes bytes, drives IMEM/status)      |
// |           master = host side (supplies bytes, observes IMEM/status)      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_data;
  logic              imem_wren;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [WCNT_W-1:0] words_written;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_addr, imem_data, imem_wren,
           cpu_hold, load_done, load_error, words_written
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_addr, imem_data, imem_wren,
           cpu_hold, load_done, load_error, words_written
  );

endinterface
`default_nettype wire

// File: rtl/imem_loader_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : loader_timer                                                   |
// | Purpose : Inactivity counter. Counts enabled cycles since the last       |
// |           clear and flags when the count sits at the limit.              |
// | Ports   : clk, rst   clock / synchronous active-high reset               |
// |           i_clear    zero the count (dominates i_enable)                 |
// |           i_enable   advance the count by one per cycle                  |
// |           i_limit    terminal count                                      |
// |           o_expired  count == i_limit                                    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module loader_timer #(
  parameter int W = 20
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_clear,
  input  wire logic         i_enable,
  input  wire logic [W-1:0] i_limit,
  output logic              o_expired
);

  logic [W-1:0] r_count;

  // Saturates at the limit so it can never wrap back below it.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != i_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == i_limit);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : imem_loader                                                    |
// | Purpose : Boot loader. Receives a LEN / data / CHK framed byte stream,   |
// |           assembles big-endian words, writes them into IMEM and releases |
// |           the CPU once the XOR checksum of the data bytes matches.       |
// | Ports   : SYS_clk    system clock (rising edge)                          |
// |           SYS_reset  synchronous active-high reset                       |
// |           bus        imem_loader_if.slave: start, rx_data/valid/ready,   |
// |                      imem_addr/data/wren, cpu_hold, load_done,           |
// |                      load_error, words_written                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  wire logic    SYS_clk,
  input  wire logic    SYS_reset,
  imem_loader_if.slave bus
);

  localparam int          TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_wren;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [23:0]       r_shift;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_word_idx;
  logic [WCNT_W-1:0] r_len;
  logic [WCNT_W-1:0] r_words;

  logic w_accept;
  logic w_active;
  logic w_expired;
  logic w_len_bad;
  logic w_last_word;
  logic w_to_error;

  assign w_accept    = bus.rx_valid & r_rx_ready;
  assign w_active    = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_len_bad   = (bus.rx_data == 8'd0) || ({24'd0, bus.rx_data} > 32'(DEPTH));
  assign w_last_word = ((r_words + 1'b1) == r_len);

  // Every path into ERROR, gathered in one place. An accepted byte always
  // beats the timeout, so the timeout term requires no acceptance.
  assign w_to_error = w_active && (
                        (!w_accept && w_expired) ||
                        ((r_state == ST_LEN) && w_accept && w_len_bad) ||
                        ((r_state == ST_CHK) && w_accept && (bus.rx_data != r_chk)));

  // Timer only runs while a frame is in flight; it is held at zero otherwise,
  // which also gives the required clear on entry to LEN.
  loader_timer #(
    .W (TW)
  ) u_timer (
    .clk       (SYS_clk),
    .rst       (SYS_reset),
    .i_clear   (w_accept | ~w_active),
    .i_enable  (w_active),
    .i_limit   (TLIMIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state    <= ST_IDLE;
      r_rx_ready <= 1'b0;
      r_wren     <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_chk      <= '0;
      r_word_idx <= '0;
      r_len      <= '0;
      r_words    <= '0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start) begin
            r_state    <= ST_LEN;
            r_rx_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_chk      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            r_len   <= bus.rx_data[WCNT_W-1:0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], bus.rx_data};
            r_chk      <= r_chk ^ bus.rx_data;
            r_byte_idx <= r_byte_idx + 1'b1;
            if (r_byte_idx == 2'd3) begin
              // Word complete: the write is presented in the following cycle.
              r_wren  <= 1'b1;
              r_addr  <= 32'(r_word_idx);
              r_data  <= {r_shift, bus.rx_data};
              r_words <= r_words + 1'b1;
              if (w_last_word) begin
                r_state <= ST_CHK;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
              end
            end
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            r_state    <= ST_DONE;
            r_rx_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase

      // Overrides the success transitions above.
      if (w_to_error) begin
        r_state    <= ST_ERROR;
        r_rx_ready <= 1'b0;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b1;
      end
    end
  end

  assign bus.rx_ready      = r_rx_ready;
  assign bus.imem_addr     = r_addr;
  assign bus.imem_data     = r_data;
  // A reset arriving in the write cycle cancels that write immediately.
  assign bus.imem_wren     = r_wren & ~SYS_reset;
  assign bus.cpu_hold      = r_cpu_hold;
  assign bus.load_done     = r_done;
  assign bus.load_error    = r_err;
  assign bus.words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_imem_loader                                                 |
// | Purpose : Self-checking bench for imem_loader. Stimulus pushes expected  |
// |           IMEM writes into a queue; a monitor pops and compares them     |
// |           whenever the loader asserts imem_wren.                         |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_acc = 0;
  wr_t  exp_q[$];

  imem_loader_if bus ();

  imem_loader #(
    .TIMEOUT_CYC (16)
  ) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one byte and hold it until accepted; returns cycles spent waiting.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    stalls = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && stalls < 20) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (bus.rx_ready !== 1'b1) begin
      check("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    end else begin
      @(posedge clk); #1;
      last_acc = cyc;
    end
  endtask

  task automatic send_word(input logic [5:0] idx, input logic [31:0] w,
                           input bit expect_wr, inout int stalls);
    int s;
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], s);
      stalls += s;
    end
    if (expect_wr) exp_q.push_back('{32'(idx), w, last_acc});
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({tag, "_wren"},     {31'd0, bus.imem_wren}, 32'd0);
    check({tag, "_addr"},     bus.imem_addr, 32'd0);
    check({tag, "_data"},     bus.imem_data, 32'd0);
    check({tag, "_hold"},     {31'd0, bus.cpu_hold}, 32'd1);
    check({tag, "_done"},     {31'd0, bus.load_done}, 32'd0);
    check({tag, "_error"},    {31'd0, bus.load_error}, 32'd0);
    check({tag, "_words"},    {25'd0, bus.words_written}, 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input int w);
    check({tag, "_done"},  {31'd0, bus.load_done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, bus.load_error}, {31'd0, e});
    check({tag, "_hold"},  {31'd0, bus.cpu_hold}, {31'd0, h});
    check({tag, "_words"}, {25'd0, bus.words_written}, 32'(w));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int tot;
    int n;
    int acc;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    fork
      begin : monitor
        wr_t e;
        forever begin
          @(negedge clk);
          if (bus.imem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
              check("unexpected_write", {31'd0, bus.imem_wren}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr",  bus.imem_addr, e.addr);
              check("wr_data",  bus.imem_data, e.data);
              check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single-word frame, good checksum
    pulse_start();
    check("t1_len_ready", {31'd0, bus.rx_ready}, 32'd1);
    send_byte(8'h01, s);
    tot = 0;
    send_word(6'd0, 32'h2008_0004, 1'b1, tot);
    send_byte(8'h2C, s);
    bus.rx_valid = 1'b0;
    check_status("t1", 1'b1, 1'b0, 1'b0, 1);
    check("t1_ready_off", {31'd0, bus.rx_ready}, 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // T3: same frame, bad checksum; word 0 still written
    pulse_start();
    check_status("t3_restart", 1'b0, 1'b0, 1'b1, 0);
    send_byte(8'h01, s);
    send_word(6'd0, 32'h2008_0004, 1'b1, tot);
    send_byte(8'h00, s);
    bus.rx_valid = 1'b0;
    check_status("t3", 1'b0, 1'b1, 1'b1, 1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // T2: three words back-to-back, CHK = 0xCC
    pulse_start();
    send_byte(8'h03, s);
    tot = 0;
    send_word(6'd0, 32'h1122_3344, 1'b1, tot);
    send_word(6'd1, 32'h5566_7788, 1'b1, tot);
    send_word(6'd2, 32'h99AA_BBCC, 1'b1, tot);
    check("t2_no_stall", 32'(tot), 32'd0);
    send_byte(8'hCC, s);
    bus.rx_valid = 1'b0;
    check_status("t2", 1'b1, 1'b0, 1'b0, 3);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // T4: LEN out of range (0 and 65)
    pulse_start();
    send_byte(8'h00, s);
    bus.rx_valid = 1'b0;
    check_status("t4_len0", 1'b0, 1'b1, 1'b1, 0);
    check("t4_len0_ready", {31'd0, bus.rx_ready}, 32'd0);
    pulse_start();
    send_byte(8'h41, s);
    bus.rx_valid = 1'b0;
    check_status("t4_len65", 1'b0, 1'b1, 1'b1, 0);

    // T5: timeout 16 cycles after last accepted byte
    pulse_start();
    send_byte(8'h02, s);
    send_word(6'd0, 32'h0102_0304, 1'b1, tot);
    send_byte(8'h05, s);
    bus.rx_valid = 1'b0;
    acc = last_acc;
    n = 0;
    while (bus.load_error !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_timeout_cycles", 32'(cyc - acc), 32'd16);
    check_status("t5", 1'b0, 1'b1, 1'b1, 1);

    // T6: reset in the cycle after a 4th byte cancels the write
    pulse_start();
    send_byte(8'h02, s);
    send_word(6'd0, 32'h0A0B_0C0D, 1'b0, tot);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("t6_reset");
    pulse_start();
    send_byte(8'h01, s);
    send_word(6'd0, 32'hDEAD_BEEF, 1'b1, tot);
    send_byte(8'h22, s);
    bus.rx_valid = 1'b0;
    check_status("t6", 1'b1, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
